// File: rtl/spi_axis_sequencer.sv
// Accelerometer SPI sequencer: two-write init, then periodic burst reads of
// 1..3 axes assembled into signed 16-bit samples, with timeout/overrun flags.
module spi_axis_sequencer #(
  parameter int NUM_AXES       = 3,
  parameter int REQ_DATA_WIDTH = 16,
  parameter int ACK_DATA_WIDTH = 8,
  parameter int PAUSE_CYCLES   = 20000,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [7:0] PWR_CTL_VAL  = 8'h08,
  parameter logic [7:0] DATA_FMT_VAL = 8'h4C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr_err,
  output logic                      host_req,
  output logic [REQ_DATA_WIDTH-1:0] host_req_data,
  input  logic                      host_ack,
  input  logic [ACK_DATA_WIDTH-1:0] host_ack_data,
  output logic                      init_done,
  output logic [16*NUM_AXES-1:0]    sample_data,
  output logic                      sample_valid,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int NBYTES = 2 * NUM_AXES;
  localparam int PW     = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    BYTE_LAST   = 3'(NBYTES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_DONE} state_e;

  state_e                      state_q;
  logic                        step_q;
  logic [2:0]                  byte_q;
  logic                        req_q;
  logic [REQ_DATA_WIDTH-1:0]   req_data_q;
  logic [PW-1:0]               period_q;
  logic [TW-1:0]               tcnt_q;
  logic                        init_done_q;
  logic [16*NUM_AXES-1:0]      shadow_q;
  logic [16*NUM_AXES-1:0]      sample_q;
  logic                        valid_q;
  logic                        err_to_q, err_ov_q;
  logic                        err_to_d, err_ov_d;
  logic                        tick, ack, timeout;

  function automatic logic [15:0] init_word(input logic step);
    return step ? {2'b00, 6'h31, DATA_FMT_VAL} : {2'b00, 6'h2D, PWR_CTL_VAL};
  endfunction

  function automatic logic [15:0] read_word(input logic [2:0] b);
    return {2'b10, 6'h32 + {3'b000, b}, 8'h00};
  endfunction

  // A flag-setting event in the same cycle as clr_err takes priority.
  always_comb begin
    tick     = init_done_q && (period_q == PERIOD_LAST);
    ack      = req_q && host_ack;
    timeout  = req_q && !host_ack && (tcnt_q == TO_LAST);
    err_to_d = timeout || (err_to_q && !clr_err);
    err_ov_d = (tick && (state_q == ST_READ || state_q == ST_DONE)) ||
               (err_ov_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      tcnt_q   <= '0;
    end else begin
      if (!init_done_q || tick) period_q <= '0;
      else                      period_q <= period_q + 1'b1;
      if (!req_q || host_ack || timeout) tcnt_q <= '0;
      else                               tcnt_q <= tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      step_q      <= 1'b0;
      byte_q      <= '0;
      req_q       <= 1'b0;
      req_data_q  <= '0;
      init_done_q <= 1'b0;
      shadow_q    <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
      case (state_q)
        // A timed-out init write is simply re-issued on the following edge.
        ST_INIT: begin
          if (!req_q) begin
            req_q      <= 1'b1;
            req_data_q <= REQ_DATA_WIDTH'(init_word(step_q));
          end else if (ack) begin
            req_q <= 1'b0;
            if (step_q) begin
              init_done_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              step_q <= 1'b1;
            end
          end else if (timeout) begin
            req_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (tick && en) begin
            state_q    <= ST_READ;
            byte_q     <= '0;
            req_q      <= 1'b1;
            req_data_q <= REQ_DATA_WIDTH'(read_word(3'd0));
          end
        end
        ST_READ: begin
          if (!req_q) begin
            req_q      <= 1'b1;
            req_data_q <= REQ_DATA_WIDTH'(read_word(byte_q));
          end else if (ack) begin
            req_q <= 1'b0;
            shadow_q[{byte_q, 3'b000} +: 8] <= host_ack_data[7:0];
            if (byte_q == BYTE_LAST) state_q <= ST_DONE;
            else                     byte_q  <= byte_q + 1'b1;
          end else if (timeout) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          sample_q <= shadow_q;
          valid_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_req      = req_q;
  assign host_req_data = req_data_q;
  assign init_done     = init_done_q;
  assign sample_data   = sample_q;
  assign sample_valid  = valid_q;
  assign err_timeout   = err_to_q;
  assign err_overrun   = err_ov_q;

endmodule
